fifo_sync_param: RTL and testbench

- Single-clock, parametrised successor to fifo_wrapper: one buffer in one clock domain with configurable width, depth and read mode.
- Adds the following, none of which fifo_wrapper has:
  - fill-level count output;
  - almost_full / almost_empty thresholds;
  - sticky overflow / underflow error flags with clear;
  - selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain; replaces fifo_wrapper where the dual-clock path is not needed.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_sync_ram.sv | 29 ++
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 tb/tb_fifo_sync_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: default sizing, read-mode
// selector and address-width helper.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;
    localparam int AF_LEVEL_DEF   = 14;
    localparam int AE_LEVEL_DEF   = 2;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } rd_mode_e;

    // Width of an address into a DEPTH-entry buffer; never below one bit
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = addrWidth(DEPTH)
)(
    input  logic                  clk,
    input  logic                  i_wrEn,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic [ADDR_WIDTH-1:0] i_rdAddr,
    output logic [DATA_WIDTH-1:0] o_rdData
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word on an accepted write
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AF_LEVEL   = AF_LEVEL_DEF,
    parameter int AE_LEVEL   = AE_LEVEL_DEF,
    parameter int FWFT       = 0
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        push,
    output logic                        full,
    output logic                        almost_full,
    output logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        pop,
    output logic                        empty,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        clr_err
);

    localparam int AW = addrWidth(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);
    localparam rd_mode_e READ_MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_pushAcc;
    logic                  w_popAcc;
    logic [DATA_WIDTH-1:0] w_rdData;

    // A pop needs stored data; a push needs room unless a pop frees a slot
    // in the same cycle, which keeps a full FIFO streaming at full rate.
    assign w_popAcc  = pop && (r_count != '0);
    assign w_pushAcc = push && ((r_count != FULL_COUNT) || w_popAcc);

    assign full         = (r_count == FULL_COUNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_COUNT);
    assign almost_empty = (r_count <= AE_COUNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk      (clk),
        .i_wrEn   (w_pushAcc),
        .i_wrAddr (r_wrPtr),
        .i_wrData (data_in),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdData)
    );

    // Advance pointers on accepted operations and track the fill level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popAcc) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushAcc, w_popAcc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps its flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && !w_pushAcc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (pop && !w_popAcc) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (READ_MODE == fifo_pkg::FWFT) begin : g_fwft
            assign data_out = empty ? '0 : w_rdData;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dataOut;

            // Registered read: capture the head word on an accepted pop, hold otherwise
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dataOut <= '0;
                end else if (w_popAcc) begin
                    r_dataOut <= w_rdData;
                end
            end

            assign data_out = r_dataOut;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed scoreboard bench for fifo_sync_param: a standard-read instance
// exercises fill/drain/errors/reset, a FWFT instance checks fall-through.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] dataIn = '0;
    logic       push = 1'b0, pop = 1'b0, clrErr = 1'b0;
    logic       full, almostFull, empty, almostEmpty, overflow, underflow;
    logic [7:0] dataOut;
    logic [4:0] count;

    logic [7:0] fDataIn = '0;
    logic       fPush = 1'b0, fPop = 1'b0, fClrErr = 1'b0;
    logic       fFull, fAlmostFull, fEmpty, fAlmostEmpty, fOverflow, fUnderflow;
    logic [7:0] fDataOut;
    logic [4:0] fCount;

    int compCount = 0;
    int errCount  = 0;

    logic [7:0] sbq[$];
    int         mCount = 0;
    logic [7:0] mDout  = '0;
    bit         mOvf   = 1'b0;
    bit         mUdf   = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dutStd (
        .clk(clk), .rst(rst), .data_in(dataIn), .push(push), .full(full),
        .almost_full(almostFull), .data_out(dataOut), .pop(pop), .empty(empty),
        .almost_empty(almostEmpty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clrErr)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dutFwft (
        .clk(clk), .rst(rst), .data_in(fDataIn), .push(fPush), .full(fFull),
        .almost_full(fAlmostFull), .data_out(fDataOut), .pop(fPop), .empty(fEmpty),
        .almost_empty(fAlmostEmpty), .count(fCount), .overflow(fOverflow),
        .underflow(fUnderflow), .clr_err(fClrErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".count"},        32'(count),       32'(mCount));
        checkOutput({tag, ".full"},         32'(full),        32'(mCount == 16));
        checkOutput({tag, ".almostFull"},   32'(almostFull),  32'(mCount >= 14));
        checkOutput({tag, ".empty"},        32'(empty),       32'(mCount == 0));
        checkOutput({tag, ".almostEmpty"},  32'(almostEmpty), 32'(mCount <= 2));
        checkOutput({tag, ".overflow"},     32'(overflow),    32'(mOvf));
        checkOutput({tag, ".underflow"},    32'(underflow),   32'(mUdf));
        checkOutput({tag, ".dataOut"},      32'(dataOut),     32'(mDout));
    endtask

    task automatic modelReset();
        sbq.delete();
        mCount = 0;
        mDout  = '0;
        mOvf   = 1'b0;
        mUdf   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the standard instance and advance the reference model
    task automatic applyStimulus(input bit p, input bit q, input logic [7:0] d, input bit c);
        bit popAcc, pushAcc;
        push   = p;
        pop    = q;
        dataIn = d;
        clrErr = c;
        popAcc  = q && (sbq.size() > 0);
        pushAcc = p && ((sbq.size() < 16) || popAcc);
        if (popAcc)  mDout = sbq.pop_front();
        if (pushAcc) sbq.push_back(d);
        mCount = sbq.size();
        if (p && !pushAcc) mOvf = 1'b1; else if (c) mOvf = 1'b0;
        if (q && !popAcc)  mUdf = 1'b1; else if (c) mUdf = 1'b0;
        tick();
        push   = 1'b0;
        pop    = 1'b0;
        clrErr = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        modelReset();
        checkAll("reset");
        checkOutput("reset.fwftEmpty", 32'(fEmpty),   32'd1);
        checkOutput("reset.fwftDout",  32'(fDataOut), 32'd0);
        rst = 1'b1;
        tick();

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
            checkAll($sformatf("fill%0d", i));
        end

        // Overflow then clear
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
        checkAll("overflow");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkAll("clrOverflow");

        // Simultaneous push and pop at full
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
            checkAll($sformatf("pushPopFull%0d", i));
        end

        // Drain remaining originals then 0x10..0x17
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkAll($sformatf("drain%0d", i));
        end

        // Underflow on empty, data_out must hold
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkAll("underflow");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkAll("clrUnderflow");

        // Push and pop together on empty: push wins, pop flags underflow
        applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
        checkAll("pushPopEmpty");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        checkAll("popAfterEmptyPair");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        end
        checkAll("preReset");
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll("midReset");
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
        checkAll("postResetPush");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkAll("postResetPop");

        // FWFT instance
        checkOutput("fwft.idleDout", 32'(fDataOut), 32'd0);
        fPush = 1'b1; fDataIn = 8'h5A;
        tick();
        fPush = 1'b0;
        checkOutput("fwft.fallThrough", 32'(fDataOut), 32'h5A);
        checkOutput("fwft.notEmpty",    32'(fEmpty),   32'd0);
        tick();
        checkOutput("fwft.holdNoPop",   32'(fDataOut), 32'h5A);
        fPop = 1'b1;
        tick();
        fPop = 1'b0;
        checkOutput("fwft.emptyAfterPop", 32'(fEmpty),   32'd1);
        checkOutput("fwft.zeroAfterPop",  32'(fDataOut), 32'd0);
        checkOutput("fwft.countAfterPop", 32'(fCount),   32'd0);
        fPush = 1'b1; fDataIn = 8'h11;
        tick();
        fDataIn = 8'h22;
        tick();
        fPush = 1'b0;
        checkOutput("fwft.head1", 32'(fDataOut), 32'h11);
        fPop = 1'b1;
        tick();
        fPop = 1'b0;
        checkOutput("fwft.head2",  32'(fDataOut), 32'h22);
        checkOutput("fwft.count1", 32'(fCount),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
